determinante_nxn_seq: RTL

Sequential determinant unit for signed square matrices of size 1x1 to 5x5, selected per operation. It is the parametrised successor to the fixed 4x4 Laplace unit in the ULA. A single combinational 3x3 cofactor core is reused across cycles, so larger sizes trade latency for area. The block has a start/busy/done handshake, configurable element, accumulator and output widths, and saturation with overflow and invalid-size flags.

---
 rtl/determinante_nxn_seq.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/determinante_nxn_seq.sv
// determinante_nxn_seq
//   Sequential determinant of a signed NxN matrix, N = 1..5. One
//   combinational 3x3 cofactor core is reused for one term per clock. N <= 3
//   needs one term, N = 4 needs four Laplace terms along row 0, and N = 5
//   needs twenty terms from a two-level Laplace expansion along rows 0 and 1.
//   The sum is clamped to OUT_W bits.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   start      operation request, sampled only in IDLE
//   matriz     25 elements, element (i,j) at [(i*5+j)*DATA_W +: DATA_W]
//   tamanho    matrix order N (valid 1..5)
//   busy       operation in progress
//   done       one-cycle pulse when resultado/overflow/erro are updated
//   resultado  saturated signed determinant, held until the next done
//   overflow   the result was clamped
//   erro       tamanho was out of range (resultado forced to 0)
//   estado     current FSM state (0 IDLE, 1 CALC, 2 FINISH), debug only
//
// Handshake: start is accepted on any rising edge where the FSM is in IDLE.
// The edge that accepts start also captures matriz and tamanho, and busy
// rises after that edge. While busy is high, start is ignored. The operation
// ends with a one-cycle done pulse and busy falling on the same edge. Because
// the FSM is back in IDLE during the done cycle, a start held high in that
// cycle is accepted immediately.
module determinante_nxn_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [25*DATA_W-1:0]    matriz,
    input  logic [7:0]              tamanho,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] resultado,
    output logic                    overflow,
    output logic                    erro,
    output logic [1:0]              estado
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t state, state_nx;

    logic signed [DATA_W-1:0] mat_r [0:24];
    logic [7:0]               n_r;
    logic [4:0]               idx;
    logic signed [ACC_W-1:0]  acc;

    logic capture, add_term, finish_ld;
    logic invalid, last_term;
    logic [4:0] idx_last;

    // Term datapath
    logic [2:0]              p_sel, q_sel;
    logic signed [ACC_W-1:0] m [0:2][0:2];
    logic signed [ACC_W-1:0] c1, c2, det, prod, term;
    logic                    neg;

    // Flat position of element (r,c); the row stride is always 5.
    function automatic logic [4:0] pos(input logic [2:0] r, input logic [2:0] c);
        return {2'b00, r} * 5'd5 + {2'b00, c};
    endfunction

    // Maps column k of a minor back to the parent column when column s
    // has been removed.
    function automatic logic [2:0] skip(input logic [2:0] k, input logic [2:0] s);
        return (k < s) ? k : k + 3'd1;
    endfunction

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last_term) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        busy      = (state != IDLE);
        capture   = (state == IDLE) && start;
        add_term  = (state == CALC);
        finish_ld = (state == FINISH);
    end

    assign estado = state;

    // ---------------- Term sequencing ----------------
    assign invalid = (n_r == 8'd0) || (n_r > 8'd5);

    always_comb begin
        case (n_r)
            8'd4:    idx_last = 5'd3;
            8'd5:    idx_last = 5'd19;
            default: idx_last = 5'd0;
        endcase
    end

    assign last_term = (idx == idx_last);

    // For N=5, idx = 4*p + q enumerates p outer and q inner.
    // For N=4, q_sel is the row-0 column c.
    assign p_sel = idx[4:2];
    assign q_sel = {1'b0, idx[1:0]};

    // Loads the 3x3 core and the cofactor multipliers for the current term.
    // Smaller matrices are padded with an identity so that det3 equals their
    // own determinant.
    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = '0;
        c1  = ONE;
        c2  = ONE;
        neg = 1'b0;
        case (n_r)
            8'd1: begin
                m[0][0] = ext(mat_r[0]);
                m[1][1] = ONE;
                m[2][2] = ONE;
            end
            8'd2: begin
                m[0][0] = ext(mat_r[0]);
                m[0][1] = ext(mat_r[1]);
                m[1][0] = ext(mat_r[5]);
                m[1][1] = ext(mat_r[6]);
                m[2][2] = ONE;
            end
            8'd3: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m[i][j] = ext(mat_r[pos(3'(i), 3'(j))]);
            end
            8'd4: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m[i][j] = ext(mat_r[pos(3'(i + 1), skip(3'(j), q_sel))]);
                c1  = ext(mat_r[pos(3'd0, q_sel)]);
                neg = q_sel[0];
            end
            8'd5: begin
                // Row-1 element b[0][q] sits in column skip(q,p) of a. The
                // 3x3 minor drops column q of b, then column p of a.
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m[i][j] = ext(mat_r[pos(3'(i + 2), skip(skip(3'(j), q_sel), p_sel))]);
                c1  = ext(mat_r[pos(3'd0, p_sel)]);
                c2  = ext(mat_r[pos(3'd1, skip(q_sel, p_sel))]);
                neg = p_sel[0] ^ q_sel[0];
            end
            default: ;
        endcase
    end

    assign det = m[0][0] * (m[1][1] * m[2][2] - m[1][2] * m[2][1])
               - m[0][1] * (m[1][0] * m[2][2] - m[1][2] * m[2][0])
               + m[0][2] * (m[1][0] * m[2][1] - m[1][1] * m[2][0]);

    assign prod = c1 * c2 * det;
    assign term = invalid ? '0 : (neg ? -prod : prod);

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int k = 0; k < 25; k++)
                mat_r[k] <= matriz[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_r       <= '0;
            idx       <= '0;
            acc       <= '0;
            done      <= 1'b0;
            resultado <= '0;
            overflow  <= 1'b0;
            erro      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capture) begin
                n_r <= tamanho;
                idx <= '0;
                acc <= '0;
            end
            if (add_term) begin
                acc <= acc + term;
                idx <= idx + 5'd1;
            end
            if (finish_ld) begin
                done <= 1'b1;
                erro <= invalid;
                if (invalid) begin
                    resultado <= '0;
                    overflow  <= 1'b0;
                end else if (acc > SAT_MAX) begin
                    resultado <= {1'b0, {(OUT_W-1){1'b1}}};
                    overflow  <= 1'b1;
                end else if (acc < SAT_MIN) begin
                    resultado <= {1'b1, {(OUT_W-1){1'b0}}};
                    overflow  <= 1'b1;
                end else begin
                    resultado <= acc[OUT_W-1:0];
                    overflow  <= 1'b0;
                end
            end
        end
    end

endmodule
